// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_unit
// Description : Instruction-fetch stage. Holds the PC, fetches one word per
//               instruction over a req/ready handshake, presents it to the
//               decoder and selects the next PC from the decoder/ALU controls.
//               Optional fetch watchdog enabled by FETCH_TIMEOUT_WDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        advance,
    input  logic        branch,
    input  logic        branch_not_equal,
    input  logic        jump,
    input  logic        jump_link,
    input  logic        zero,
    input  logic [31:0] imm_ext,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    output logic        link_we,
    output logic [31:0] retired,
    output logic        fetch_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] w_pc4;
    logic        w_branch_taken;
    logic [31:0] w_next_pc;

    assign w_pc4 = pc_q + 32'd4;

    // Next-PC selection: jump overrides branch (branch bits may be X on jumps)
    always_comb begin
        w_branch_taken = (branch & zero) | (branch_not_equal & ~zero);
        if (jump) begin
            w_next_pc = {w_pc4[31:28], instr_q[25:0], 2'b00};
        end else if (w_branch_taken) begin
            w_next_pc = w_pc4 + {imm_ext[29:0], 2'b00};
        end else begin
            w_next_pc = w_pc4;
        end
    end

    // Fetch/execute sequencing and handshake outputs
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        valid_d   = valid_q;
        retired_d = retired_q;
        imem_req  = 1'b0;
        link_we   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (advance) begin
                    pc_d      = w_next_pc;
                    retired_d = retired_q + 32'd1;
                    valid_d   = 1'b0;
                    link_we   = jump_link & valid_q;
                    state_d   = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight fetch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 32'd0;
            valid_q   <= 1'b0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            valid_q   <= valid_d;
            retired_q <= retired_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign retired     = retired_q;
    assign link_addr   = w_pc4;

`ifdef FETCH_TIMEOUT_WDOG_EN
    localparam logic [8:0] c_TIMEOUT = 9'(TIMEOUT_CYCLES);

    logic [7:0] wd_cnt_q, wd_cnt_d;
    logic       timeout_q, timeout_d;

    // Count unanswered FETCH cycles; flag is sticky and purely diagnostic
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        timeout_d = timeout_q;
        if ((state_d == FETCH) && (state_q != FETCH)) begin
            wd_cnt_d = 8'd0;
        end else if ((state_q == FETCH) && !imem_ready) begin
            if (wd_cnt_q != 8'hFF) begin
                wd_cnt_d = wd_cnt_q + 8'd1;
            end
            if (({1'b0, wd_cnt_q} + 9'd1) >= c_TIMEOUT) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Watchdog registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q  <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign fetch_timeout = timeout_q;
`else
    assign fetch_timeout = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch stage directly upstream of the opcode decoder. Holds the PC, fetches a word from instruction memory over a req/ready handshake, and presents the held instruction; instr[31:26] drives the decoder's OPcode input.
- Consumes the decoder's branch, branch_not_equal, jump and jump_link outputs, together with the ALU zero flag and the extended immediate, to select the next PC.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, wait-cycle limit for the optional watchdog (legal range 1..255).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, equals pc.
- imem_rdata  in  32  fetched word, sampled when imem_req & imem_ready.
- imem_ready  in  1  memory response valid.
- instr  out  32  held instruction.
- instr_valid  out  1  instr is current; decode and execute may use it.
- advance  in  1  datapath has finished the current instruction.
- branch  in  1  beq qualifier.
- branch_not_equal  in  1  bne qualifier.
- jump  in  1  j/jal.
- jump_link  in  1  jal; link_addr must be written.
- zero  in  1  ALU zero flag.
- imm_ext  in  32  sign-extended 16-bit immediate.
- pc  out  32  address of instr.
- link_addr  out  32  pc+4, valid while instr_valid.
- link_we  out  1  jump_link & instr_valid & advance.
- retired  out  32  count of completed instructions.
- fetch_timeout  out  1  optional watchdog flag; tied to 0 when the feature is compiled out.

Behaviour:
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, retired=0, fetch_timeout=0, state=IDLE.
- FSM states are IDLE, FETCH and EXEC.
  - IDLE: imem_req=0. Moves to FETCH on the next edge unconditionally, so the first request occurs one cycle after reset deasserts.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ready=1, instr<=imem_rdata, instr_valid<=1 and the state moves to EXEC. While imem_ready=0, the FSM stays in FETCH with address stable.
  - EXEC: imem_req=0 and instr_valid=1. On advance=1, pc<=next_pc, retired<=retired+1 (wraps at 2^32), instr_valid<=0 and the state moves to FETCH. While advance=0, everything holds.
- imem_ready outside FETCH is ignored.
- Minimum instruction period is 2 cycles: ready in the first FETCH cycle, then advance in the first EXEC cycle.
- next_pc is combinational and evaluated with the EXEC-cycle inputs. Priority order:
  1. If jump=1: {pc4[31:28], instr[25:0], 2'b00}. branch and branch_not_equal are ignored, because the decoder may drive them X for jumps.
  2. Else if (branch & zero) | (branch_not_equal & ~zero): pc4 + (imm_ext<<2), with 32-bit modular add.
  3. Else: pc4, where pc4=pc+4 and wraps 32'hFFFF_FFFC -> 0.
- branch and branch_not_equal both 1 is illegal from the decoder; the branch is taken if either condition holds.
- link_addr = pc+4 combinationally.
- link_we is a single-cycle pulse, only in the advancing EXEC cycle.
- Reset asserted in any state, including mid-fetch, immediately forces the reset values. A pending memory response is discarded.
- Control inputs are not sampled outside EXEC.

Optional Feature:
- Macro FETCH_TIMEOUT_WDOG_EN.
- Defined:
  - An 8-bit counter clears on entry to FETCH and increments each FETCH cycle with imem_ready=0.
  - When it reaches TIMEOUT_CYCLES, fetch_timeout<=1. The flag is sticky until reset.
  - The FSM keeps waiting; the flag is diagnostic only.
- Undefined: no counter; fetch_timeout=0 constantly.

Test Plan:
- Reset, then imem_ready=1 and advance=1 constantly, no control -> imem_addr steps 0, 4, 8, 12 every 2 cycles; retired=3 after the third advance; first imem_req seen in cycle 2 after reset release.
- pc=0x10, branch=1, zero=1, imm_ext=0xFFFF_FFFE, advance -> next imem_addr=0x0C. Repeat with zero=0 -> 0x14.
- pc=0x20, branch_not_equal=1, zero=0, imm_ext=3 -> next imem_addr=0x30.
- pc=0x4000_0000, instr=0x0C00_0010 (jal), jump=1, jump_link=1, branch=X -> link_we pulses once with link_addr=0x4000_0004; next imem_addr=0x4000_0040.
- Stalls: imem_ready low 5 cycles, then advance low 3 cycles -> imem_addr stable through the fetch wait, instr_valid held, retired unchanged until advance; reset pulsed mid-FETCH -> pc=RESET_PC, instr_valid=0, imem_req=0.
- With FETCH_TIMEOUT_WDOG_EN and TIMEOUT_CYCLES=4: hold imem_ready=0 -> fetch_timeout rises after 4 wait cycles and stays 1 after ready returns. Without the macro -> stays 0.
